// File: rtl/control_pipe.sv
// control_pipe: RV32I control unit for the pipelined core.
//   ID stage : combinational opcode/funct3 decode (id_imm_src and the EX control word).
//   ID/EX    : control register with flush (highest) > stall > load priority.
//   EX stage : branch/jump resolution from ALU flags; ex_pc_src redirects the PC in the
//              same cycle and flush_id kills the younger instruction in IF/ID.
//   Illegal opcodes travel to EX as a live bubble that pulses ex_illegal once and bumps a
//   saturating counter.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   id_valid/opcode/funct3      instruction fields held in IF/ID
//   stall, flush_ext            hazard-unit hold, external flush
//   ex_zero/ex_lt/ex_ltu        ALU flags from EX
//   id_imm_src                  immediate format (0 I, 1 S, 2 B, 3 J, 4 U)
//   ex_*                        registered ID/EX control word
//   ex_pc_src, flush_id         redirect and IF/ID kill, combinational from ID/EX
//   ill_count                   saturating illegal-instruction count
module control_pipe #(
  parameter bit          UPPER_EN  = 1'b1,
  parameter int unsigned ILL_CNT_W = 8,
  parameter int unsigned ALU_OP_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [6:0]           id_opcode,
  input  logic [2:0]           id_funct3,
  input  logic                 stall,
  input  logic                 flush_ext,
  input  logic                 ex_zero,
  input  logic                 ex_lt,
  input  logic                 ex_ltu,
  output logic [2:0]           id_imm_src,
  output logic                 ex_valid,
  output logic                 ex_reg_write,
  output logic                 ex_mem_write,
  output logic [1:0]           ex_result_src,
  output logic                 ex_alu_src,
  output logic                 ex_alu_src_a,
  output logic [ALU_OP_W-1:0]  ex_alu_op,
  output logic                 ex_jalr,
  output logic                 ex_pc_src,
  output logic                 flush_id,
  output logic                 ex_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [6:0] OpR     = 7'd51;
  localparam logic [6:0] OpLoad  = 7'd3;
  localparam logic [6:0] OpAluI  = 7'd19;
  localparam logic [6:0] OpStore = 7'd35;
  localparam logic [6:0] OpBr    = 7'd99;
  localparam logic [6:0] OpJal   = 7'd111;
  localparam logic [6:0] OpJalr  = 7'd103;
  localparam logic [6:0] OpLui   = 7'd55;
  localparam logic [6:0] OpAuipc = 7'd23;

  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmB = 3'd2;
  localparam logic [2:0] ImmJ = 3'd3;
  localparam logic [2:0] ImmU = 3'd4;

  localparam logic [1:0] ResAlu = 2'd0;
  localparam logic [1:0] ResMem = 2'd1;
  localparam logic [1:0] ResPc4 = 2'd2;
  localparam logic [1:0] ResImm = 2'd3;

  localparam logic [ALU_OP_W-1:0] AluAdd   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] AluSub   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] AluFunct = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] AluPassB = ALU_OP_W'(3);

  // ID decode results
  logic                dec_reg_write;
  logic                dec_mem_write;
  logic [1:0]          dec_result_src;
  logic                dec_alu_src;
  logic                dec_alu_src_a;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_jalr;
  logic                dec_branch;
  logic                dec_jump;
  logic                dec_illegal;
  logic                dec_live;

  // EX-side branch/jump state
  logic [2:0] funct3_q;
  logic       branch_q;
  logic       jump_q;
  logic       br_cond;

  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_write  = 1'b0;
    dec_result_src = ResAlu;
    dec_alu_src    = 1'b0;
    dec_alu_src_a  = 1'b0;
    dec_alu_op     = AluAdd;
    dec_jalr       = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_illegal    = 1'b0;
    id_imm_src     = ImmI;
    case (id_opcode)
      OpR: begin
        dec_reg_write = 1'b1;
        dec_alu_op    = AluFunct;
      end
      OpLoad: begin
        dec_reg_write  = 1'b1;
        dec_result_src = ResMem;
        dec_alu_src    = 1'b1;
      end
      OpAluI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_op    = AluFunct;
      end
      OpStore: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        id_imm_src    = ImmS;
      end
      OpBr: begin
        id_imm_src = ImmB;
        dec_alu_op = AluSub;
        // funct3 010/011 have no branch meaning
        if (id_funct3[2:1] == 2'b01) begin
          dec_illegal = 1'b1;
        end else begin
          dec_branch = 1'b1;
        end
      end
      OpJal: begin
        dec_reg_write  = 1'b1;
        dec_result_src = ResPc4;
        dec_jump       = 1'b1;
        id_imm_src     = ImmJ;
      end
      OpJalr: begin
        dec_reg_write  = 1'b1;
        dec_result_src = ResPc4;
        dec_alu_src    = 1'b1;
        dec_jalr       = 1'b1;
        dec_jump       = 1'b1;
      end
      OpLui: begin
        id_imm_src = ImmU;
        if (UPPER_EN) begin
          dec_reg_write  = 1'b1;
          dec_result_src = ResImm;
          dec_alu_src    = 1'b1;
          dec_alu_op     = AluPassB;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpAuipc: begin
        id_imm_src = ImmU;
        if (UPPER_EN) begin
          dec_reg_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_alu_src_a = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Empty slots and illegal instructions enter EX with every control field cleared.
  assign dec_live = id_valid & ~dec_illegal;

  always_comb begin
    br_cond = 1'b0;
    case (funct3_q)
      3'b000:  br_cond = ex_zero;
      3'b001:  br_cond = ~ex_zero;
      3'b100:  br_cond = ex_lt;
      3'b101:  br_cond = ~ex_lt;
      3'b110:  br_cond = ex_ltu;
      3'b111:  br_cond = ~ex_ltu;
      default: br_cond = 1'b0;
    endcase
    ex_pc_src = ex_valid & (jump_q | (branch_q & br_cond));
  end

  // A taken redirect squashes both the younger instruction in ID and its ID/EX load.
  assign flush_id = ex_pc_src | flush_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_result_src <= ResAlu;
      ex_alu_src    <= 1'b0;
      ex_alu_src_a  <= 1'b0;
      ex_alu_op     <= AluAdd;
      ex_jalr       <= 1'b0;
      ex_illegal    <= 1'b0;
      funct3_q      <= 3'b000;
      branch_q      <= 1'b0;
      jump_q        <= 1'b0;
      ill_count     <= '0;
    end else if (flush_id) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_result_src <= ResAlu;
      ex_alu_src    <= 1'b0;
      ex_alu_src_a  <= 1'b0;
      ex_alu_op     <= AluAdd;
      ex_jalr       <= 1'b0;
      ex_illegal    <= 1'b0;
      funct3_q      <= 3'b000;
      branch_q      <= 1'b0;
      jump_q        <= 1'b0;
    end else if (stall) begin
      // Everything holds except the illegal pulse, so a stalled illegal counts once.
      ex_illegal <= 1'b0;
    end else begin
      ex_valid      <= id_valid;
      ex_reg_write  <= dec_live & dec_reg_write;
      ex_mem_write  <= dec_live & dec_mem_write;
      ex_result_src <= dec_live ? dec_result_src : ResAlu;
      ex_alu_src    <= dec_live & dec_alu_src;
      ex_alu_src_a  <= dec_live & dec_alu_src_a;
      ex_alu_op     <= dec_live ? dec_alu_op : AluAdd;
      ex_jalr       <= dec_live & dec_jalr;
      ex_illegal    <= id_valid & dec_illegal;
      funct3_q      <= dec_live ? id_funct3 : 3'b000;
      branch_q      <= dec_live & dec_branch;
      jump_q        <= dec_live & dec_jump;
      if (id_valid && dec_illegal && (ill_count != '1)) begin
        ill_count <= ill_count + ILL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: table of decode/branch vectors, hand sequences for reset, stall,
// flush and illegal saturation, then randomized traffic against a slot-level model.
module tb_control_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [6:0] id_opcode = 7'd0;
  logic [2:0] id_funct3 = 3'd0;
  logic       stall = 1'b0;
  logic       flush_ext = 1'b0;
  logic       ex_zero = 1'b0;
  logic       ex_lt = 1'b0;
  logic       ex_ltu = 1'b0;

  logic [2:0] id_imm_src;
  logic       ex_valid, ex_reg_write, ex_mem_write, ex_alu_src, ex_alu_src_a, ex_jalr;
  logic [1:0] ex_result_src, ex_alu_op;
  logic       ex_pc_src, flush_id, ex_illegal;
  logic [7:0] ill_count;

  logic [2:0] nu_imm_src;
  logic       nu_valid, nu_reg_write, nu_mem_write, nu_alu_src, nu_alu_src_a, nu_jalr;
  logic [1:0] nu_result_src, nu_alu_op;
  logic       nu_pc_src, nu_flush_id, nu_illegal;
  logic [7:0] nu_ill_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  control_pipe #(.UPPER_EN(1'b1), .ILL_CNT_W(8), .ALU_OP_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .stall(stall), .flush_ext(flush_ext), .ex_zero(ex_zero),
    .ex_lt(ex_lt), .ex_ltu(ex_ltu), .id_imm_src(id_imm_src), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_result_src(ex_result_src), .ex_alu_src(ex_alu_src), .ex_alu_src_a(ex_alu_src_a),
    .ex_alu_op(ex_alu_op), .ex_jalr(ex_jalr), .ex_pc_src(ex_pc_src), .flush_id(flush_id),
    .ex_illegal(ex_illegal), .ill_count(ill_count)
  );

  control_pipe #(.UPPER_EN(1'b0), .ILL_CNT_W(8), .ALU_OP_W(2)) dut_nu (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .stall(stall), .flush_ext(flush_ext), .ex_zero(ex_zero),
    .ex_lt(ex_lt), .ex_ltu(ex_ltu), .id_imm_src(nu_imm_src), .ex_valid(nu_valid),
    .ex_reg_write(nu_reg_write), .ex_mem_write(nu_mem_write),
    .ex_result_src(nu_result_src), .ex_alu_src(nu_alu_src), .ex_alu_src_a(nu_alu_src_a),
    .ex_alu_op(nu_alu_op), .ex_jalr(nu_jalr), .ex_pc_src(nu_pc_src), .flush_id(nu_flush_id),
    .ex_illegal(nu_illegal), .ill_count(nu_ill_count)
  );

  // Model of the instruction sitting in the EX slot
  typedef struct packed {
    logic       valid, rw, mw;
    logic [1:0] rs;
    logic       as, asa;
    logic [1:0] aop;
    logic       jalr, ill, branch, jump;
    logic [2:0] f3;
  } ctrl_t;

  ctrl_t m = '0;
  int    m_cnt = 0;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z, lt, ltu;
    logic       rw, mw;
    logic [1:0] rs;
    logic       as, asa;
    logic [1:0] aop;
    logic       jalr, ill, pc;
    logic [2:0] imm;  // 7 = not checked
  } tv_t;

  tv_t tv[17];

  function automatic tv_t mk(input int op, f3, z, lt, ltu, rw, mw, rs, as_, asa, aop, jalr,
                             ill, pc, imm);
    tv_t t;
    t.op = 7'(op); t.f3 = 3'(f3); t.z = 1'(z); t.lt = 1'(lt); t.ltu = 1'(ltu);
    t.rw = 1'(rw); t.mw = 1'(mw); t.rs = 2'(rs); t.as = 1'(as_); t.asa = 1'(asa);
    t.aop = 2'(aop); t.jalr = 1'(jalr); t.ill = 1'(ill); t.pc = 1'(pc); t.imm = 3'(imm);
    return t;
  endfunction

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3,
                                    input logic uen);
    if (op == 7'd99) return !(f3 == 3'd2 || f3 == 3'd3);
    if (op == 7'd55 || op == 7'd23) return uen;
    return op == 7'd51 || op == 7'd3 || op == 7'd19 || op == 7'd35 || op == 7'd111 ||
           op == 7'd103;
  endfunction

  function automatic ctrl_t dec(input logic [6:0] op, input logic [2:0] f3, input logic v);
    ctrl_t r;
    r = '0;
    if (!v) return r;
    r.valid = 1'b1;
    if (!is_legal(op, f3, 1'b1)) begin
      r.ill = 1'b1;
      return r;
    end
    r.f3 = f3;
    case (op)
      7'd51:  begin r.rw = 1; r.aop = 2; end
      7'd3:   begin r.rw = 1; r.rs = 1; r.as = 1; end
      7'd19:  begin r.rw = 1; r.as = 1; r.aop = 2; end
      7'd35:  begin r.mw = 1; r.as = 1; end
      7'd99:  begin r.aop = 1; r.branch = 1; end
      7'd111: begin r.rw = 1; r.rs = 2; r.jump = 1; end
      7'd103: begin r.rw = 1; r.rs = 2; r.as = 1; r.jalr = 1; r.jump = 1; end
      7'd55:  begin r.rw = 1; r.rs = 3; r.as = 1; r.aop = 3; end
      default: begin r.rw = 1; r.as = 1; r.asa = 1; end  // AUIPC
    endcase
    return r;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == 7'd35) return 3'd1;
    if (op == 7'd99) return 3'd2;
    if (op == 7'd111) return 3'd3;
    if (op == 7'd55 || op == 7'd23) return 3'd4;
    return 3'd0;
  endfunction

  // Branch condition: funct3[2] picks lt-family, [1] picks unsigned, [0] inverts.
  function automatic logic model_pc();
    logic c;
    c = m.f3[2] ? (m.f3[1] ? ex_ltu : ex_lt) : ex_zero;
    c = c ^ m.f3[0];
    return m.valid & (m.jump | (m.branch & c));
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name);
    logic [20:0] act, exp;
    logic        pc;
    pc  = model_pc();
    act = {ex_valid, ex_reg_write, ex_mem_write, ex_result_src, ex_alu_src, ex_alu_src_a,
           ex_alu_op, ex_jalr, ex_illegal, ex_pc_src, flush_id, ill_count};
    exp = {m.valid, m.rw, m.mw, m.rs, m.as, m.asa, m.aop, m.jalr, m.ill, pc, pc | flush_ext,
           8'(m_cnt)};
    cmp(name, 32'(act), 32'(exp));
  endtask

  task automatic step();
    ctrl_t nx;
    int    nc;
    nc = m_cnt;
    if (model_pc() || flush_ext) begin
      nx = '0;
    end else if (stall) begin
      nx = m;
      nx.ill = 1'b0;
    end else begin
      nx = dec(id_opcode, id_funct3, id_valid);
      if (nx.ill && nc < 255) nc++;
    end
    @(posedge clk);
    #1;
    m = nx;
    m_cnt = nc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    m = '0;
    m_cnt = 0;
    check_all("reset_async");
    #2;
    rst = 1'b0;
  endtask

  task automatic set_id(input logic v, input logic [6:0] op, input logic [2:0] f3);
    id_valid = v;
    id_opcode = op;
    id_funct3 = f3;
  endtask

  function automatic logic [6:0] rand_illegal();
    logic [6:0] op;
    do op = 7'($urandom_range(0, 127)); while (is_legal(op, 3'd0, 1'b1));
    return op;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = mk(51,  0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 7);
    tv[1]  = mk(3,   2, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(19,  0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 0);
    tv[3]  = mk(35,  2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    tv[4]  = mk(99,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
    tv[5]  = mk(99,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    tv[6]  = mk(99,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
    tv[7]  = mk(99,  4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
    tv[8]  = mk(99,  5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    tv[9]  = mk(99,  6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    tv[10] = mk(99,  7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
    tv[11] = mk(99,  2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7);
    tv[12] = mk(111, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1, 3);
    tv[13] = mk(103, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 1, 0, 1, 0);
    tv[14] = mk(55,  0, 0, 0, 0, 1, 0, 3, 1, 0, 3, 0, 0, 0, 4);
    tv[15] = mk(23,  0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 4);
    tv[16] = mk(127, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7);

    // Reset with an R-type waiting in ID, then one edge loads it
    @(posedge clk); #1;
    set_id(1'b1, 7'd51, 3'd0);
    do_reset();
    step();
    cmp("rst_release_rw", 32'(ex_reg_write), 32'd1);
    cmp("rst_release_aop", 32'(ex_alu_op), 32'd2);
    check_all("rst_release");

    // Table vectors: load, set flags, check EX word, then drain
    for (int i = 0; i < 17; i++) begin
      {ex_zero, ex_lt, ex_ltu} = 3'b000;
      set_id(1'b1, tv[i].op, tv[i].f3);
      #1;
      if (tv[i].imm != 3'd7) cmp($sformatf("tbl%0d_imm", i), 32'(id_imm_src), 32'(tv[i].imm));
      step();
      {ex_zero, ex_lt, ex_ltu} = {tv[i].z, tv[i].lt, tv[i].ltu};
      set_id(1'b0, 7'd0, 3'd0);
      #1;
      cmp($sformatf("tbl%0d_word", i),
          32'({ex_valid, ex_reg_write, ex_mem_write, ex_result_src, ex_alu_src, ex_alu_src_a,
               ex_alu_op, ex_jalr, ex_illegal, ex_pc_src, flush_id}),
          32'({1'b1, tv[i].rw, tv[i].mw, tv[i].rs, tv[i].as, tv[i].asa, tv[i].aop,
               tv[i].jalr, tv[i].ill, tv[i].pc, tv[i].pc}));
      check_all($sformatf("tbl%0d_model", i));
      step();
    end

    // Taken BEQ redirects and kills the younger instruction
    do_reset();
    {ex_zero, ex_lt, ex_ltu} = 3'b000;
    set_id(1'b1, 7'd99, 3'd0);
    step();
    ex_zero = 1'b1;
    set_id(1'b1, 7'd51, 3'd0);
    #1;
    cmp("beq_pc_src", 32'(ex_pc_src), 32'd1);
    cmp("beq_flush_id", 32'(flush_id), 32'd1);
    step();
    cmp("beq_bubble", 32'({ex_valid, ex_reg_write}), 32'd0);
    ex_zero = 1'b0;
    set_id(1'b1, 7'd99, 3'd6);
    step();
    ex_ltu = 1'b0;
    #1;
    cmp("bltu_not_taken", 32'(ex_pc_src), 32'd0);
    check_all("bltu_model");

    // Stall holds a load while a store waits in ID
    set_id(1'b1, 7'd3, 3'd2);
    step();
    set_id(1'b1, 7'd35, 3'd2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      cmp($sformatf("stall%0d_hold", k), 32'({ex_result_src, ex_mem_write}), 32'({2'd1, 1'b0}));
    end
    stall = 1'b0;
    step();
    cmp("stall_release_mw", 32'(ex_mem_write), 32'd1);

    // Flush beats stall on the same edge
    set_id(1'b1, 7'd51, 3'd0);
    step();
    stall = 1'b1;
    flush_ext = 1'b1;
    step();
    cmp("flush_over_stall", 32'({ex_valid, ex_reg_write}), 32'd0);
    stall = 1'b0;
    flush_ext = 1'b0;
    #1;
    check_all("flush_model");

    // 301 illegal instructions, each separated by an empty slot
    do_reset();
    for (int k = 0; k <= 300; k++) begin
      set_id(1'b1, (k == 0) ? 7'h7f : rand_illegal(), 3'd0);
      step();
      cmp("ill_pulse", 32'({ex_illegal, ex_valid, ex_reg_write, ex_mem_write}), 32'b1100);
      set_id(1'b0, 7'd0, 3'd0);
      step();
      cmp("ill_gap", 32'(ex_illegal), 32'd0);
    end
    cmp("ill_saturate", 32'(ill_count), 32'd255);
    check_all("ill_model");

    // LUI with and without upper-immediate support
    do_reset();
    set_id(1'b1, 7'd55, 3'd0);
    #1;
    cmp("lui_imm_src", 32'(id_imm_src), 32'd4);
    step();
    cmp("lui_en_word", 32'({ex_result_src, ex_alu_op}), 32'({2'd3, 2'd3}));
    cmp("lui_dis_illegal", 32'({nu_illegal, nu_reg_write, nu_ill_count}), 32'({2'b10, 8'd1}));

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: op = 7'd51;  1: op = 7'd3;   2: op = 7'd19;  3: op = 7'd35;  4: op = 7'd99;
        5: op = 7'd111; 6: op = 7'd103; 7: op = 7'd55;  8: op = 7'd23;
        default: op = rand_illegal();
      endcase
      set_id(($urandom_range(0, 7) != 0), op, 3'($urandom_range(0, 7)));
      stall = ($urandom_range(0, 3) == 0);
      flush_ext = ($urandom_range(0, 15) == 0);
      {ex_zero, ex_lt, ex_ltu} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) do_reset();
      #1;
      check_all("rand_pre");
      if (id_valid && is_legal(op, id_funct3, 1'b1) && op != 7'd51)
        cmp("rand_imm", 32'(id_imm_src), 32'(imm_of(op)));
      step();
    end
    stall = 1'b0;
    flush_ext = 1'b0;
    #1;
    check_all("rand_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
